// File: rtl/seq_shifter_if.sv
// Handshake and data bundle between the ALU shift path and seq_shifter.
interface seq_shifter_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) ();
    logic               start;
    logic [1:0]         op;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   data_in;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;

    // Requester side: issues operations and observes status/result.
    modport master (
        output start, op, shamt, data_in,
        input  busy, done, result
    );

    // Shifter side.
    modport slave (
        input  start, op, shamt, data_in,
        output busy, done, result
    );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle barrel-shifter replacement: moves the operand one bit position
// per clock in SLL/SRL/SRA/ROTR mode under a start/busy/done handshake.
module seq_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    seq_shifter_if.slave bus
);

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic [1:0]         op_q, op_d;

    // Single-position shift of the working register; shamt >= WIDTH needs no
    // special case because repeated steps saturate (SLL/SRL/SRA) or wrap (ROTR).
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] w,
                                                    input logic [1:0]       mode);
        logic [WIDTH-1:0] r;
        case (mode)
            OP_SLL:  r = {w[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, w[WIDTH-1:1]};
            OP_SRA:  r = {w[WIDTH-1], w[WIDTH-1:1]};
            OP_ROTR: r = {w[0], w[WIDTH-1:1]};
            default: r = w;
        endcase
        return r;
    endfunction

    // State, operand, counter and latched mode registers; reset clears all.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            count_q <= '0;
            op_q    <= OP_SLL;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
            op_q    <= op_d;
        end
    end

    // Next-state logic: accept start only outside SHIFT, step once per cycle.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        op_d    = op_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    work_d  = bus.data_in;
                    count_d = bus.shamt;
                    state_d = (bus.shamt == '0) ? DONE : SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                work_d  = shift_step(work_q, op_q);
                count_d = count_q - 1'b1;
                if (count_q == SHAMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy   = (state_q == SHIFT);
    assign bus.done   = (state_q == DONE);
    assign bus.result = work_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed and randomized self-checking bench for seq_shifter.
module tb_seq_shifter;

    localparam logic [1:0] SLL  = 2'b00;
    localparam logic [1:0] SRL  = 2'b01;
    localparam logic [1:0] SRA  = 2'b10;
    localparam logic [1:0] ROTR = 2'b11;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    seq_shifter_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    seq_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: the whole shift computed in one go with plain arithmetic.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d, input int s);
        int r;
        case (o)
            SLL:  return (s >= 32) ? 32'h0 : (d << s);
            SRL:  return (s >= 32) ? 32'h0 : (d >> s);
            SRA:  return 32'($signed(d) >>> ((s >= 32) ? 31 : s));
            default: begin
                r = s % 32;
                return (r == 0) ? d : ((d >> r) | (d << (32 - r)));
            end
        endcase
    endfunction

    // Entered and left at posedge+1. Issues one operation, waits for done
    // (bounded), checks latency, busy cycle count and result. With poke set,
    // junk starts are raised at cycles 3 and 10 while the shift is running.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                         input int s, input logic [31:0] exp, input bit poke);
        int n;
        int busy_cnt;
        busy_cnt     = 0;
        bus.start    = 1'b1;
        bus.op       = o;
        bus.data_in  = d;
        bus.shamt    = 5'(s);
        @(posedge clk); #1;
        n         = 1;
        bus.start = 1'b0;
        while (!bus.done && n <= 40) begin
            if (bus.busy) busy_cnt++;
            if (poke && (n == 3 || n == 10)) begin
                bus.start   = 1'b1;
                bus.op      = ~o;
                bus.data_in = $urandom;
                bus.shamt   = 5'd3;
            end
            @(posedge clk); #1;
            n++;
            bus.start = 1'b0;
        end
        check({tag, "_latency"}, 32'(n), 32'(s + 1));
        check({tag, "_result"}, bus.result, exp);
        check({tag, "_busycyc"}, 32'(busy_cnt), 32'(s));
    endtask

    // One idle cycle: done must drop and result must hold.
    task automatic idle_check(input string tag, input logic [31:0] held);
        @(posedge clk); #1;
        check({tag, "_done_low"}, 32'(bus.done), 32'h0);
        check({tag, "_busy_low"}, 32'(bus.busy), 32'h0);
        check({tag, "_hold"}, bus.result, held);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] rd;
        int          rs;
        checks      = 0;
        errors      = 0;
        reset_n     = 1'b0;
        bus.start   = 1'b0;
        bus.op      = SLL;
        bus.shamt   = '0;
        bus.data_in = '0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_result", bus.result, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        do_op("sll2", SLL, 32'h0000_0001, 2, 32'h0000_0004, 1'b0);
        idle_check("sll2", 32'h0000_0004);
        do_op("sra4", SRA, 32'h8000_0000, 4, 32'hF800_0000, 1'b0);
        idle_check("sra4", 32'hF800_0000);
        do_op("srl4", SRL, 32'h8000_0000, 4, 32'h0800_0000, 1'b0);
        do_op("rotr8", ROTR, 32'h0000_00F1, 8, 32'hF100_0000, 1'b0);
        idle_check("rotr8", 32'hF100_0000);
        do_op("zero", SRA, 32'h1234_5678, 0, 32'h1234_5678, 1'b0);
        idle_check("zero", 32'h1234_5678);
        do_op("sll31", SLL, 32'hFFFF_FFFF, 31, 32'h8000_0000, 1'b1);
        idle_check("sll31", 32'h8000_0000);
        do_op("sra31", SRA, 32'h8000_0000, 31, 32'hFFFF_FFFF, 1'b0);
        do_op("rotr31", ROTR, 32'h0000_0001, 31, 32'h0000_0002, 1'b0);
        idle_check("rotr31", 32'h0000_0002);

        // Back-to-back: the second start is driven while done is high.
        do_op("chain1", SRL, 32'hF000_0000, 4, 32'h0F00_0000, 1'b0);
        do_op("chain2", SLL, 32'h0000_0001, 1, 32'h0000_0002, 1'b0);
        idle_check("chain2", 32'h0000_0002);

        // Reset between edges partway through a long shift.
        bus.start   = 1'b1;
        bus.op      = SLL;
        bus.data_in = 32'h0000_FFFF;
        bus.shamt   = 5'd20;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        check("pre_rst_busy", 32'(bus.busy), 32'h1);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'h0);
        check("mid_rst_done", 32'(bus.done), 32'h0);
        check("mid_rst_result", bus.result, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_done", 32'(bus.done), 32'h0);
        end
        do_op("after_rst", SRA, 32'h8000_0001, 3, 32'hF000_0000, 1'b0);
        idle_check("after_rst", 32'hF000_0000);

        // Randomized operations, optionally chained, against the model.
        for (int k = 0; k < 40; k++) begin
            ro = 2'($urandom_range(0, 3));
            rd = $urandom;
            rs = $urandom_range(0, 31);
            do_op("rand", ro, rd, rs, model(ro, rd, rs), ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 2) == 0) idle_check("rand", model(ro, rd, rs));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Parametrised multi-cycle shifter for the MIPS32 datapath.
- Replaces the fixed, combinational shift-by-2 with a variable shift amount and four modes: SLL, SRL, SRA, ROTR.
- Performs one bit position per clock under a start/busy/done handshake.
- Feeds the ALU's shift path for sll/srl/sra/sllv/srlv/srav and a rotate-right extension.

Parameters:
- WIDTH, 32, data width in bits; must be 2 or more.
- SHAMT_W, 5, width of the shift-amount field; must satisfy 2^SHAMT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when the block is not busy.
- op  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROTR.
- shamt  input  SHAMT_W  shift amount, unsigned.
- data_in  input  WIDTH  operand.
- busy  output  1  high while shifting.
- done  output  1  one-cycle pulse; result is valid.
- result  output  WIDTH  shifted value.

Behaviour:
- Reset: asserting reset_n=0 immediately forces state=IDLE, busy=0, done=0, result=0 and count=0, independent of clk. Reset release takes effect at the next edge.
- States: IDLE, SHIFT, DONE.
- IDLE/DONE with start=1 at an edge:
  - latch op, load working register with data_in, load count with shamt.
  - if shamt==0: go to DONE (result=data_in).
  - otherwise: go to SHIFT.
- IDLE/DONE with start=0 at an edge: go to or stay in IDLE; result holds its value.
- SHIFT, each edge: shift the working register by 1 and decrement count. When count becomes 0, go to DONE.
- Per-step shift rules (the latched op is used; op changes mid-operation are ignored):
  - SLL: shift left by 1, fill LSB with 0.
  - SRL: shift right by 1, fill MSB with 0.
  - SRA: shift right by 1, replicate MSB.
  - ROTR: rotate right by 1; the old LSB becomes the MSB.
- shamt >= WIDTH: shift by the full shamt, no modulo. SLL/SRL give 0; SRA gives all sign bits. ROTR wraps naturally, i.e. shamt mod WIDTH.
- busy=1 exactly while state==SHIFT. done=1 exactly while state==DONE, which lasts one cycle unless a new start chains.
- result mirrors the working register and is stable whenever busy=0.
- Latency: done is high after exactly shamt+1 rising edges, counting the edge that samples start. Throughput: the next start is accepted in the same cycle done is high (back-to-back).
- start while busy: ignored, with no effect on the operation or its inputs. No queuing.
- Reset mid-operation: the operation is abandoned and no done pulse is produced.

Test Plan:
- SLL, data_in=0x00000001, shamt=2 -> done after 3 edges, result=0x00000004; busy high for 2 cycles.
- SRA, data_in=0x80000000, shamt=4 -> done after 5 edges, result=0xF8000000. SRL with the same stimulus -> 0x08000000.
- ROTR, data_in=0x000000F1, shamt=8 -> result=0xF1000000. Then shamt=0 with data_in=0x12345678 -> done after 1 edge, result=0x12345678, busy never asserted.
- SLL, data_in=0xFFFFFFFF, shamt=31: assert start with different op/data at cycles 3 and 10 -> both ignored; done after 32 edges, result=0x80000000.
- Back-to-back chaining: SRL 0xF0000000 by 4 (-> 0x0F000000), then start asserted in the done cycle for SLL 0x1 by 1 -> second done 2 edges later, result=0x00000002.
- Reset mid-operation: drop reset_n between edges at cycle 5 of a shamt=20 shift -> busy, done and result go to 0 immediately; no done pulse; a new start after reset release works normally.
